fdiv_iter: RTL and testbench
============================

// Module: fdiv_iter
// PURPOSE
//  Multi-cycle IEEE-754 divider: result = op_a / op_b. Runs in fp32 or fp16 mode.
//  Companion to fadd in the FP unit. Shares fadd's operand/mode/round_mode/flags conventions.
//  Uses a start/busy/done handshake so the ALU sequencer can stall while it runs.
// PARAMETERS
//  QBITS  27  quotient bits per divide: 24 mantissa + guard + round + 1 spare; sticky comes from remainder
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  start       in   1   request; sampled only when busy==0
//  op_a        in   32  dividend; fp16 mode uses [15:0]
//  op_b        in   32  divisor; fp16 mode uses [15:0]
//  round_mode  in   1   1 = round-to-nearest-even, 0 = truncate
//  mode_fp     in   1   1 = fp32, 0 = fp16
//  busy        out  1   high from accept to end of ROUND
//  done        out  1   one-cycle pulse, result/flags valid
//  result      out  32  fp32 word, or {16'b0,fp16}; held until next accept
//  flags       out  5   {NV,OF,UF,DZ,NX}; held with result
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, result, flags all 0. Also applies mid-operation: work is abandoned.
//  Operands, round_mode and mode_fp are latched at accept. Later input changes are ignored.
//  fp16 input: each operand is converted by fp16_32 before latching.
//  States: IDLE -> LOAD/classify (on the accept edge) -> DIV (QBITS cycles) -> ROUND (1) -> DONE (1) -> IDLE.
//  Accept occurs at edge 0:
//   - normal operands: DIV runs cycles 1..27, ROUND is cycle 28, done=1 in cycle 29;
//   - special operands: go straight to DONE, done=1 in cycle 1.
//  start while busy: ignored. start during DONE: accepted; next op begins, done drops.
//  Special cases, in priority order:
//   - NaN in, inf/inf, or 0/0 -> 32'h7FC00000, NV=1;
//   - finite nonzero / 0 -> {s,8'hFF,0}, DZ=1;
//   - inf/finite -> signed inf;
//   - 0/x or finite/inf -> signed zero.
//   Sign is always s_a^s_b. All other flags are 0.
//  Subnormal input: hidden bit 0. Mantissa is left-normalized at load and its exponent adjusted.
//  Exponent: 10-bit signed e = e_a - e_b + 127.
//  Restoring divide: rem = f_a. Each DIV cycle:
//   - q = {q, rem>=f_b};
//   - if the bit is 1, rem -= f_b;
//   - rem <<= 1.
//  After DIV:
//   - if q[26]==0, shift q left 1 and decrement e;
//   - G = q[2], R = q[1], S = q[0] | (rem!=0).
//  Rounding:
//   - round_mode=1 (RNE): increment if G&(R|S|lsb). Mantissa carry-out shifts right and increments e;
//   - round_mode=0: drop G, R, S.
//  NX = G|R|S.
//  Overflow (e>=255 after rounding): +/-inf, OF=1, NX=1.
//  Underflow (e<=0): flush to signed zero, UF=1, NX=1. No subnormal results.
//  fp16 output: fp32 result passes through fp32_16; result = {16'b0,out16}. Double rounding is accepted.
// STRUCTURE
//  fp_pkg holds shared constants:
//   - QNAN32 = 32'h7FC00000;
//   - BIAS = 127;
//   - flag bit indices (NV=4, OF=3, UF=2, DZ=1, NX=0);
//   - state encodings (IDLE, DIV, ROUND, DONE).
//  Sub-module fdiv_core: restoring mantissa divider with load/step inputs, q/rem outputs, and iteration counter.
//  FSM, classification, exponent logic and rounding stay in fdiv_iter.
//  Reuses the existing fp16_32 (x2) and fp32_16 converters.
// TESTING
//  6.0/2.0: 40C00000/40000000, fp32, RNE
//   -> result 40400000, flags 00000, done in cycle 29 exactly.
//  1.0/3.0: 3F800000/40400000
//   -> RNE gives 3EAAAAAB flags 00001; truncate gives 3EAAAAAA flags 00001.
//  Specials:
//   - 3F800000/00000000 -> 7F800000 flags 00010, done in cycle 1;
//   - 0/0 -> 7FC00000 flags 10000;
//   - BF800000/7F800000 -> 80000000.
//  Overflow: 7F7FFFFF/3F000000 -> 7F800000 flags 01001.
//  fp16: op_a=4600, op_b=4000, mode_fp=0 -> result 00004200, flags 00000.
//  Reset mid-op: rst at cycle 10 -> next cycle busy=0, done=0, result=0.
//   A start pulsed during busy (before rst) is ignored.
//   A following start on 40C00000/40000000 completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP-unit constants, FSM state encoding and an fp32 operand unpack helper.
// Contents:
//   QBITS, QNAN32, BIAS       divider sizing and IEEE constants
//   FLAG_*                    bit positions inside the 5-bit {NV,OF,UF,DZ,NX} flag word
//   state_e                   fdiv_iter sequencer states
//   unpack32()                fp32 -> {24-bit normalized mantissa, 10-bit signed exponent}
package fp_pkg;

  localparam int unsigned QBITS  = 27;
  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam int          BIAS   = 127;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_OF = 3;
  localparam int unsigned FLAG_UF = 2;
  localparam int unsigned FLAG_DZ = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef enum logic [1:0] {StIdle, StDiv, StRound, StDone} state_e;

  typedef struct packed {
    logic        [23:0] mant;
    logic signed [9:0]  exp;
  } unpk_t;

  // Subnormals have no hidden bit; shift the leading one up to bit 23 and
  // lower the exponent to match so the divider always sees a normalized value.
  function automatic unpk_t unpack32(input logic [31:0] x);
    unpk_t       u;
    logic [23:0] m;
    int          lz;
    if (x[30:23] != 8'd0) begin
      u.mant = {1'b1, x[22:0]};
      u.exp  = {2'b00, x[30:23]};
    end else begin
      m  = {1'b0, x[22:0]};
      lz = 0;
      for (int i = 0; i < 24; i++) begin
        if (m[i]) lz = 23 - i;
      end
      u.mant = m << lz;
      u.exp  = 10'(1 - lz);
    end
    return u;
  endfunction

endpackage

// File: rtl/fdiv_core.sv
// Restoring mantissa divider: one quotient bit per step, QBITS steps per divide.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_load          load dividend/divisor, clear quotient and step counter
//   i_step          produce one quotient bit
//   i_f_a, i_f_b    normalized 24-bit mantissas (bit 23 set)
//   o_q             quotient, MSB = integer bit
//   o_rem           partial remainder (nonzero means more quotient bits exist)
//   o_last          the current step is the final one
module fdiv_core import fp_pkg::*; (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [23:0]      i_f_a,
  input  logic [23:0]      i_f_b,
  output logic [QBITS-1:0] o_q,
  output logic [24:0]      o_rem,
  output logic             o_last
);

  localparam int unsigned CntW = $clog2(QBITS);

  logic [23:0]      r_fb;
  logic [QBITS-1:0] r_q;
  logic [24:0]      r_rem;
  logic [CntW-1:0]  r_cnt;
  logic             w_ge;
  logic [23:0]      w_diff;

  // rem < 2*f_b always holds, so after a subtract-or-keep it fits in 24 bits
  assign w_ge   = r_rem >= {1'b0, r_fb};
  assign w_diff = w_ge ? 24'(r_rem - {1'b0, r_fb}) : r_rem[23:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fb  <= '0;
      r_q   <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_fb  <= i_f_b;
      r_q   <= '0;
      r_rem <= {1'b0, i_f_a};
      r_cnt <= '0;
    end else if (i_step) begin
      r_q   <= {r_q[QBITS-2:0], w_ge};
      r_rem <= {w_diff, 1'b0};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_q    = r_q;
  assign o_rem  = r_rem;
  assign o_last = (r_cnt == CntW'(QBITS - 1));

endmodule

// File: rtl/fp16_32.sv
// fp16 -> fp32 widening converter (exact). fp16 subnormals become fp32 normals.
// Ports:
//   i_h  fp16 input word
//   o_f  fp32 output word
module fp16_32 (
  input  logic [15:0] i_h,
  output logic [31:0] o_f
);

  always_comb begin
    int p;
    p = 0;
    // position of the leading one in a subnormal mantissa
    for (int i = 0; i < 10; i++) begin
      if (i_h[i]) p = i;
    end
    if (i_h[14:10] == 5'h1F) begin
      o_f = {i_h[15], 8'hFF, i_h[9:0], 13'd0};
    end else if (i_h[14:10] == 5'd0) begin
      if (i_h[9:0] == 10'd0) begin
        o_f = {i_h[15], 31'd0};
      end else begin
        // value = 1.f * 2^(p-24); the leading one is shifted out as the hidden bit
        o_f = {i_h[15], 8'(p + 103), 23'({i_h[9:0], 13'd0} << (10 - p))};
      end
    end else begin
      o_f = {i_h[15], 8'(i_h[14:10]) + 8'd112, i_h[9:0], 13'd0};
    end
  end

endmodule

// File: rtl/fp32_16.sv
// fp32 -> fp16 narrowing converter. Rounds RNE or truncates; no subnormal outputs.
// Ports:
//   i_f    fp32 input word
//   i_rne  1 = round-to-nearest-even, 0 = truncate
//   o_h    fp16 output word
//   o_of   finite input overflowed to inf
//   o_uf   finite input flushed to zero
//   o_nx   result inexact
module fp32_16 (
  input  logic [31:0] i_f,
  input  logic        i_rne,
  output logic [15:0] o_h,
  output logic        o_of,
  output logic        o_uf,
  output logic        o_nx
);

  logic               w_g;
  logic               w_st;
  logic               w_inc;
  logic [10:0]        w_sum;
  logic signed [9:0]  w_e;

  assign w_g   = i_f[12];
  assign w_st  = |i_f[11:0];
  assign w_inc = i_rne & w_g & (w_st | i_f[13]);
  assign w_sum = {1'b0, i_f[22:13]} + 11'(w_inc);
  // rebias 127 -> 15, plus one on mantissa carry-out
  assign w_e   = $signed({2'b00, i_f[30:23]}) - 10'sd112 + (w_sum[10] ? 10'sd1 : 10'sd0);

  always_comb begin
    o_h  = '0;
    o_of = 1'b0;
    o_uf = 1'b0;
    o_nx = 1'b0;
    if (&i_f[30:23]) begin
      o_h = (|i_f[22:0]) ? 16'h7E00 : {i_f[31], 5'h1F, 10'd0};
    end else if (i_f[30:23] == 8'd0) begin
      o_h = {i_f[31], 15'd0};
    end else begin
      o_nx = w_g | w_st;
      if (w_e >= 10'sd31) begin
        o_h  = {i_f[31], 5'h1F, 10'd0};
        o_of = 1'b1;
        o_nx = 1'b1;
      end else if (w_e <= 10'sd0) begin
        o_h  = {i_f[31], 15'd0};
        o_uf = 1'b1;
        o_nx = 1'b1;
      end else begin
        o_h = {i_f[31], w_e[4:0], w_sum[9:0]};
      end
    end
  end

endmodule

// File: rtl/fdiv_iter.sv
// Multi-cycle IEEE-754 divider (fp32 or fp16), result = op_a / op_b.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (abandons any operation)
//   i_start             request, sampled only when not busy
//   i_op_a, i_op_b      operands; fp16 mode uses [15:0]
//   i_round_mode        1 = RNE, 0 = truncate
//   i_mode_fp           1 = fp32, 0 = fp16
//   o_busy              high from accept to end of rounding
//   o_done              one-cycle pulse, result/flags valid
//   o_result            fp32 word or {16'b0, fp16}; held until next completion
//   o_flags             {NV,OF,UF,DZ,NX}
module fdiv_iter import fp_pkg::*; (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic        i_round_mode,
  input  logic        i_mode_fp,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic [4:0]  o_flags
);

  state_e             r_state;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic               r_rne;
  logic               r_fp32;

  // operand conversion and classification (on the accept edge)
  logic [31:0] w_a16_32, w_b16_32, w_a32, w_b32;
  logic        w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
  logic        w_sign, w_nv, w_dz, w_special, w_accept;
  unpk_t       w_ua, w_ub;
  logic signed [9:0] w_exp;
  logic [31:0] w_spec32;
  logic [4:0]  w_spec_fl;

  fp16_32 u_cvt_a (.i_h(i_op_a[15:0]), .o_f(w_a16_32));
  fp16_32 u_cvt_b (.i_h(i_op_b[15:0]), .o_f(w_b16_32));

  assign w_a32    = i_mode_fp ? i_op_a : w_a16_32;
  assign w_b32    = i_mode_fp ? i_op_b : w_b16_32;
  assign w_a_nan  = (&w_a32[30:23]) & (|w_a32[22:0]);
  assign w_a_inf  = (&w_a32[30:23]) & ~(|w_a32[22:0]);
  assign w_a_zero = ~(|w_a32[30:0]);
  assign w_b_nan  = (&w_b32[30:23]) & (|w_b32[22:0]);
  assign w_b_inf  = (&w_b32[30:23]) & ~(|w_b32[22:0]);
  assign w_b_zero = ~(|w_b32[30:0]);
  assign w_sign   = w_a32[31] ^ w_b32[31];

  assign w_nv      = w_a_nan | w_b_nan | (w_a_inf & w_b_inf) | (w_a_zero & w_b_zero);
  assign w_dz      = w_b_zero & ~w_a_zero & ~w_a_inf;
  assign w_special = w_nv | w_dz | w_a_inf | w_a_zero | w_b_inf;
  assign w_accept  = i_start & ((r_state == StIdle) | (r_state == StDone));

  assign w_ua  = unpack32(w_a32);
  assign w_ub  = unpack32(w_b32);
  assign w_exp = w_ua.exp - w_ub.exp + 10'(BIAS);

  always_comb begin
    w_spec32  = {w_sign, 31'd0};
    w_spec_fl = '0;
    if (w_nv) begin
      w_spec32           = QNAN32;
      w_spec_fl[FLAG_NV] = 1'b1;
    end else if (w_dz) begin
      w_spec32           = {w_sign, 8'hFF, 23'd0};
      w_spec_fl[FLAG_DZ] = 1'b1;
    end else if (w_a_inf) begin
      w_spec32 = {w_sign, 8'hFF, 23'd0};
    end
  end

  // mantissa divider
  logic [QBITS-1:0] w_q;
  logic [24:0]      w_rem;
  logic             w_last;

  fdiv_core u_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_accept),
    .i_step (r_state == StDiv),
    .i_f_a  (w_ua.mant),
    .i_f_b  (w_ub.mant),
    .o_q    (w_q),
    .o_rem  (w_rem),
    .o_last (w_last)
  );

  // normalize, round, range-check
  logic [25:0]       w_norm;
  logic signed [9:0] w_e1, w_e2;
  logic              w_g, w_r, w_s, w_inc;
  logic [24:0]       w_sum;
  logic [22:0]       w_frac;
  logic [31:0]       w_rnd32;
  logic [4:0]        w_rnd_fl;

  // hidden bit is implicit in w_norm; quotient < 1 means one more shift
  assign w_norm = w_q[26] ? w_q[25:0] : {w_q[24:0], 1'b0};
  assign w_e1   = w_q[26] ? r_exp : r_exp - 10'sd1;
  assign w_g    = w_norm[2];
  assign w_r    = w_norm[1];
  assign w_s    = w_norm[0] | (|w_rem);
  assign w_inc  = r_rne & w_g & (w_r | w_s | w_norm[3]);
  assign w_sum  = {2'b01, w_norm[25:3]} + 25'(w_inc);
  assign w_frac = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
  assign w_e2   = w_sum[24] ? w_e1 + 10'sd1 : w_e1;

  always_comb begin
    w_rnd32           = {r_sign, w_e2[7:0], w_frac};
    w_rnd_fl          = '0;
    w_rnd_fl[FLAG_NX] = w_g | w_r | w_s;
    if (w_e2 >= 10'sd255) begin
      w_rnd32           = {r_sign, 8'hFF, 23'd0};
      w_rnd_fl[FLAG_OF] = 1'b1;
      w_rnd_fl[FLAG_NX] = 1'b1;
    end else if (w_e2 <= 10'sd0) begin
      w_rnd32           = {r_sign, 31'd0};
      w_rnd_fl[FLAG_UF] = 1'b1;
      w_rnd_fl[FLAG_NX] = 1'b1;
    end
  end

  // one output converter shared by the special path (accept edge) and the ROUND state
  logic        w_in_round, w_fin_fp32, w_fin_rne;
  logic [31:0] w_fin32, w_out_res;
  logic [4:0]  w_fin_fl, w_out_fl;
  logic [15:0] w_h;
  logic        w_h_of, w_h_uf, w_h_nx;

  assign w_in_round = (r_state == StRound);
  assign w_fin32    = w_in_round ? w_rnd32  : w_spec32;
  assign w_fin_fl   = w_in_round ? w_rnd_fl : w_spec_fl;
  assign w_fin_fp32 = w_in_round ? r_fp32   : i_mode_fp;
  assign w_fin_rne  = w_in_round ? r_rne    : i_round_mode;

  fp32_16 u_cvt_out (
    .i_f   (w_fin32),
    .i_rne (w_fin_rne),
    .o_h   (w_h),
    .o_of  (w_h_of),
    .o_uf  (w_h_uf),
    .o_nx  (w_h_nx)
  );

  assign w_out_res = w_fin_fp32 ? w_fin32  : {16'd0, w_h};
  assign w_out_fl  = w_fin_fp32 ? w_fin_fl : w_fin_fl | {1'b0, w_h_of, w_h_uf, 1'b0, w_h_nx};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_rne    <= 1'b0;
      r_fp32   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (w_accept) begin
            r_sign <= w_sign;
            r_exp  <= w_exp;
            r_rne  <= i_round_mode;
            r_fp32 <= i_mode_fp;
            if (w_special) begin
              r_state  <= StDone;
              o_done   <= 1'b1;
              o_result <= w_out_res;
              o_flags  <= w_out_fl;
            end else begin
              r_state <= StDiv;
              o_busy  <= 1'b1;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StDiv: begin
          if (w_last) r_state <= StRound;
        end
        StRound: begin
          r_state  <= StDone;
          o_busy   <= 1'b0;
          o_done   <= 1'b1;
          o_result <= w_out_res;
          o_flags  <= w_out_fl;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
module tb_fdiv_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        round_mode;
  logic        mode_fp;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  flags;

  int n_vec = 0;
  int n_err = 0;

  fdiv_iter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_op_a       (op_a),
    .i_op_b       (op_b),
    .i_round_mode (round_mode),
    .i_mode_fp    (mode_fp),
    .o_busy       (busy),
    .o_done       (done),
    .o_result     (result),
    .o_flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        rm;
    logic        mf;
    logic [31:0] res;
    logic [4:0]  fl;
    logic [5:0]  cyc;
  } vec_t;

  localparam int NVec = 16;
  vec_t vecs [NVec];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Accept on the next rising edge, scramble inputs afterwards, then wait for done.
  // Returns the cycle (1 = first cycle after accept) in which done was seen, 0 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rm,
                        input logic mf, output logic [31:0] res, output logic [4:0] fl,
                        output int cyc, output logic busy1);
    op_a       = a;
    op_b       = b;
    round_mode = rm;
    mode_fp    = mf;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    op_a       = 32'hFFFF_FFFF;
    op_b       = 32'h0000_0000;
    round_mode = ~rm;
    mode_fp    = ~mf;
    cyc        = 0;
    busy1      = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = busy;
      if (done) begin
        cyc = n;
        break;
      end
    end
    res = result;
    fl  = flags;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [4:0]  fl;
    int          cyc;
    logic        busy1;
    logic        seen_done;
    logic        busy_c10;

    //                a             b            rm    mf    result        flags  cycle
    vecs[0]  = '{32'h40C00000, 32'h40000000, 1'b1, 1'b1, 32'h40400000, 5'h00, 6'd29};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 1'b1, 1'b1, 32'h3EAAAAAB, 5'h01, 6'd29};
    vecs[2]  = '{32'h3F800000, 32'h40400000, 1'b0, 1'b1, 32'h3EAAAAAA, 5'h01, 6'd29};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 1'b1, 1'b1, 32'h7F800000, 5'h02, 6'd1};
    vecs[4]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h7FC00000, 5'h10, 6'd1};
    vecs[5]  = '{32'hBF800000, 32'h7F800000, 1'b1, 1'b1, 32'h80000000, 5'h00, 6'd1};
    vecs[6]  = '{32'h7F7FFFFF, 32'h3F000000, 1'b1, 1'b1, 32'h7F800000, 5'h09, 6'd29};
    vecs[7]  = '{32'h00800000, 32'h7F000000, 1'b1, 1'b1, 32'h00000000, 5'h05, 6'd29};
    vecs[8]  = '{32'h00400000, 32'h3E800000, 1'b1, 1'b1, 32'h01000000, 5'h00, 6'd29};
    vecs[9]  = '{32'hC0C00000, 32'h40000000, 1'b1, 1'b1, 32'hC0400000, 5'h00, 6'd29};
    vecs[10] = '{32'h00004600, 32'h00004000, 1'b1, 1'b0, 32'h00004200, 5'h00, 6'd29};
    vecs[11] = '{32'h00000001, 32'h00000400, 1'b1, 1'b0, 32'h00001400, 5'h00, 6'd29};
    vecs[12] = '{32'h00003C00, 32'h00004200, 1'b1, 1'b0, 32'h00003555, 5'h01, 6'd29};
    vecs[13] = '{32'h7FC00000, 32'h3F800000, 1'b1, 1'b1, 32'h7FC00000, 5'h10, 6'd1};
    vecs[14] = '{32'h00007BFF, 32'h00003800, 1'b1, 1'b0, 32'h00007C00, 5'h09, 6'd29};
    vecs[15] = '{32'hFF800000, 32'h40000000, 1'b1, 1'b1, 32'hFF800000, 5'h00, 6'd1};

    rst        = 1'b1;
    start      = 1'b0;
    op_a       = '0;
    op_b       = '0;
    round_mode = 1'b1;
    mode_fp    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset result", result, 32'd0);
    check_eq("reset flags", 32'(flags), 32'd0);
    rst = 1'b0;

    // back-to-back: each run_op after the first is accepted during the DONE cycle
    for (int i = 0; i < NVec; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].mf, res, fl, cyc, busy1);
      check_eq($sformatf("v%0d result", i), res, vecs[i].res);
      check_eq($sformatf("v%0d flags", i), 32'(fl), 32'(vecs[i].fl));
      check_eq($sformatf("v%0d done cycle", i), 32'(cyc), 32'(vecs[i].cyc));
      check_eq($sformatf("v%0d busy c1", i), 32'(busy1), 32'(vecs[i].cyc == 6'd29));
    end

    // reset mid-operation, with an ignored start pulse while busy
    op_a       = 32'h40C00000;
    op_b       = 32'h40000000;
    round_mode = 1'b1;
    mode_fp    = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    seen_done = 1'b0;
    busy_c10  = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (n == 5) begin
        op_a  = 32'h3F800000;
        op_b  = 32'h00000000;
        start = 1'b1;
      end
      if (n == 6) start = 1'b0;
      if (n == 10) begin
        busy_c10 = busy;
        rst      = 1'b1;
      end
    end
    @(negedge clk);
    check_eq("midop no done", 32'(seen_done), 32'd0);
    check_eq("midop busy c10", 32'(busy_c10), 32'd1);
    check_eq("midop rst busy", 32'(busy), 32'd0);
    check_eq("midop rst done", 32'(done), 32'd0);
    check_eq("midop rst result", result, 32'd0);
    check_eq("midop rst flags", 32'(flags), 32'd0);
    rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, 1'b1, 1'b1, res, fl, cyc, busy1);
    check_eq("post rst result", res, 32'h40400000);
    check_eq("post rst flags", 32'(fl), 32'd0);
    check_eq("post rst cycle", 32'(cyc), 32'd29);

    @(negedge clk);
    check_eq("done pulse width", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
